sram_fifo_mc_1port: RTL and testbench
=====================================

// Module: sram_fifo_mc_1port
// PURPOSE
//  Multi-channel FIFO: NCH logical FIFOs share one single-port SRAM.
//  Each channel has its own first-word-fall-through (FWFT) output register.
//  Used where several AER event streams buffer into one SRAM macro.
//  Adds three features to the single-channel wrapper: channel select,
//  round-robin prefetch arbitration, and per-channel flush.
// PARAMETERS
//  NCH    4   number of channels; power of 2, >=2
//  WIDTH  16  data width; SRAM word width (no byte lanes)
//  DEPTH  64  total SRAM words; DEPTH/NCH is a power of 2
//  CH_DEPTH (localparam) = DEPTH/NCH, the SRAM words per channel
// PORTS
//  clk         in   1                 clock; all logic on posedge
//  rst         in   1                 asynchronous reset, active-high
//  flush       in   NCH               sync per-channel clear
//  wr_en       in   1                 write request
//  wr_ch       in   $clog2(NCH)       target channel of the write
//  wr_data     in   WIDTH             write data
//  full        out  NCH               channel cannot accept a write
//  rd_en       in   NCH               pop request, per channel
//  rd_valid    out  NCH               rd_data[ch] is valid now (FWFT)
//  rd_data     out  NCH*WIDTH         head word; channel ch at [ch*WIDTH+:WIDTH]
//  numel       out  NCH*($clog2(CH_DEPTH+1)+1)  occupancy, including the output register
//  sram_ce     out  1                 SRAM chip enable
//  sram_we     out  1                 1 = write, 0 = read
//  sram_addr   out  $clog2(DEPTH)     {ch, ptr}
//  sram_wdata  out  WIDTH             = wr_data
//  sram_rdata  in   WIDTH             read data, one cycle after a read
// BEHAVIOUR
//  Reset: all pointers, counters and numel = 0; all states EMPTY.
//   Outputs: rd_valid=0, rd_data=0, full=0, sram_ce=0, sram_we=0.
//  Per-channel state (ch_state_e):
//   EMPTY  no head word.
//   FETCH  SRAM read in flight; data arrives next cycle.
//   VALID  output register holds the head word.
//  Accepted write: wr_en && !full[wr_ch]. A write to a full channel is
//   dropped; there is no error flag.
//  Bypass path: if sram_cnt[ch]==0 and ch is EMPTY, or VALID with rd_en[ch]:
//   wr_data loads the output register directly; no SRAM access.
//   rd_valid rises the next cycle (1-cycle latency).
//  Otherwise the write goes to SRAM: sram_ce=1, sram_we=1,
//   addr={wr_ch,wr_ptr[ch]}; wr_ptr[ch] and sram_cnt[ch] increment.
//  Pop: rd_en[ch] && rd_valid[ch]. rd_data is the popped word in the same
//   cycle. rd_en while !rd_valid is ignored.
//  Prefetch request[ch]: sram_cnt[ch]>0, and ch is EMPTY, or VALID and
//   popped this cycle.
//  Port arbitration (one access per cycle):
//   - An SRAM-bound write has priority.
//   - Otherwise the sram_fifo_rr_arb grant among prefetch requests issues a
//     read: {ch,rd_ptr[ch]}; rd_ptr and sram_cnt decrement; ch -> FETCH.
//   - The next cycle, sram_rdata loads the output register; FETCH -> VALID.
//  A pop followed by a refill gives one bubble cycle (rd_valid=0), or more
//   if the port is busy with writes.
//  full[ch] = (sram_cnt[ch]==CH_DEPTH).
//  numel[ch] = sram_cnt[ch] + (state==VALID||FETCH).
//  Pointers wrap modulo CH_DEPTH, with no gap at the wrap.
//  Same-cycle write and pop on one channel: both take effect; numel unchanged.
//  flush[ch]: ptrs, cnt and state -> EMPTY the next cycle. Also:
//   - a same-cycle write to ch is dropped;
//   - in-flight FETCH data for ch is discarded;
//   - other channels are unaffected.
//  rst asserted mid-operation: immediate return to reset values;
//   SRAM contents are don't-care.
// STRUCTURE
//  aer_pkg: add typedef enum logic [1:0] {CH_EMPTY,CH_FETCH,CH_VALID}
//   ch_state_e.
//  Sub-module sram_fifo_rr_arb #(N): request/grant one-hot arbiter.
//   Rotating priority; advances only when a grant is used.
//  Per-channel state lives in generate-loop arrays; one shared port mux.
// TESTING
//  1 Reset, then write 0xA5A5 to ch2 -> next cycle rd_valid[2]=1,
//    rd_data[2]=0xA5A5, numel[2]=1; no sram_ce pulse.
//  2 Write ch1 CH_DEPTH+2 words, no pops -> full[1]=1 after 17 words (CH_DEPTH=16).
//    Extra write dropped; pops return 0,1,..16 in order across the wrap.
//  3 All 4 channels hold SRAM data, then pop all each cycle -> prefetch
//    grants rotate 0,1,2,3; no channel starved; data order preserved.
//  4 Continuous writes to ch0 while ch3 is popped -> ch3 refill waits for an
//    idle write cycle; rd_valid[3] stays low until then; no data loss.
//  5 flush[1] in the cycle ch1 is FETCH -> sram_rdata is discarded next
//    cycle; rd_valid[1]=0, numel[1]=0; ch0/ch2 numel unchanged.
//  6 Assert rst mid-burst for 1 cycle -> all outputs at reset values
//    immediately; the next write behaves as in scenario 1.

Source files
------------

// File: rtl/sram_fifo_mc_1port_pkg.sv
// sram_fifo_mc_1port_pkg: shared types for the multi-channel SRAM FIFO
package sram_fifo_mc_1port_pkg;
   typedef enum logic [1:0] {CH_EMPTY, CH_FETCH, CH_VALID} ch_state_e;
endpackage

// File: rtl/sram_fifo_rr_arb.sv
// sram_fifo_rr_arb: rotating-priority one-hot arbiter, advances only on a grant
module sram_fifo_rr_arb #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);
   localparam int IW = $clog2(N);
   logic [IW-1:0] ptr, idx;
   logic          hit;
   always_comb begin
      hit     = 1'b0;
      gnt_idx = ptr;
      idx     = ptr;
      for (int i = 0; i < N; i++) begin
         idx = ptr + IW'(i);
         if (!hit && req[idx]) begin
            hit     = 1'b1;
            gnt_idx = idx;
         end
      end
      gnt = hit ? N'(1) << gnt_idx : '0;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (hit) ptr <= gnt_idx + 1'b1;
endmodule

// File: rtl/sram_fifo_mc_1port.sv
// sram_fifo_mc_1port: NCH FWFT FIFOs sharing one single-port SRAM, each with its own output register
module sram_fifo_mc_1port
   import sram_fifo_mc_1port_pkg::*;
#(
   parameter  int NCH      = 4,
   parameter  int WIDTH    = 16,
   parameter  int DEPTH    = 64,
   localparam int CH_DEPTH = DEPTH / NCH,
   localparam int CW       = $clog2(NCH),
   localparam int PW       = $clog2(CH_DEPTH),
   localparam int SW       = $clog2(CH_DEPTH + 1),
   localparam int NW       = SW + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       flush,
   input  logic                 wr_en,
   input  logic [CW-1:0]        wr_ch,
   input  logic [WIDTH-1:0]     wr_data,
   output logic [NCH-1:0]       full,
   input  logic [NCH-1:0]       rd_en,
   output logic [NCH-1:0]       rd_valid,
   output logic [NCH*WIDTH-1:0] rd_data,
   output logic [NCH*NW-1:0]    numel,
   output logic                 sram_ce,
   output logic                 sram_we,
   output logic [$clog2(DEPTH)-1:0] sram_addr,
   output logic [WIDTH-1:0]     sram_wdata,
   input  logic [WIDTH-1:0]     sram_rdata
);
   ch_state_e        state    [NCH];
   logic [PW-1:0]    wr_ptr   [NCH];
   logic [PW-1:0]    rd_ptr   [NCH];
   logic [SW-1:0]    sram_cnt [NCH];
   logic [WIDTH-1:0] data     [NCH];
   logic [NCH-1:0]   pop, req, gnt;
   logic [CW-1:0]    rd_ch;
   logic             wr_acc, byp, sram_wr;
   // gating with rst keeps the SRAM port quiet while reset is held
   assign wr_acc     = !rst && wr_en && !full[wr_ch] && !flush[wr_ch];
   assign byp        = sram_cnt[wr_ch] == '0 && (state[wr_ch] == CH_EMPTY || pop[wr_ch]);
   assign sram_wr    = wr_acc && !byp;
   assign sram_ce    = sram_wr || |gnt;
   assign sram_we    = sram_wr;
   assign sram_addr  = sram_wr ? {wr_ch, wr_ptr[wr_ch]} : {rd_ch, rd_ptr[rd_ch]};
   assign sram_wdata = wr_data;
   sram_fifo_rr_arb #(.N(NCH)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req & {NCH{!sram_wr}}),
      .gnt     (gnt),
      .gnt_idx (rd_ch)
   );
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic wr_here, byp_here;
      assign pop[c]      = rd_en[c] && state[c] == CH_VALID;
      assign req[c]      = sram_cnt[c] != '0 && (state[c] == CH_EMPTY || pop[c]) && !flush[c];
      assign wr_here     = sram_wr && wr_ch == CW'(c);
      assign byp_here    = wr_acc && byp && wr_ch == CW'(c);
      assign full[c]     = sram_cnt[c] == SW'(CH_DEPTH);
      assign rd_valid[c] = state[c] == CH_VALID;
      assign rd_data[c*WIDTH +: WIDTH] = data[c];
      assign numel[c*NW +: NW] = NW'(sram_cnt[c]) + NW'(state[c] != CH_EMPTY);
      always_ff @(posedge clk or posedge rst)
         if (rst || flush[c]) begin
            wr_ptr[c]   <= '0;
            rd_ptr[c]   <= '0;
            sram_cnt[c] <= '0;
            state[c]    <= CH_EMPTY;
            data[c]     <= '0;
         end else begin
            wr_ptr[c]   <= wr_ptr[c] + PW'(wr_here);
            rd_ptr[c]   <= rd_ptr[c] + PW'(gnt[c]);
            sram_cnt[c] <= sram_cnt[c] + SW'(wr_here) - SW'(gnt[c]);
            state[c]    <= gnt[c] ? CH_FETCH : byp_here || state[c] == CH_FETCH ? CH_VALID : pop[c] ? CH_EMPTY : state[c];
            if (byp_here) data[c] <= wr_data;
            else if (state[c] == CH_FETCH) data[c] <= sram_rdata;
         end
   end
endmodule

// File: tb/tb_sram_fifo_mc_1port.sv
// tb_sram_fifo_mc_1port: directed self-checking bench with a behavioural single-port SRAM
module tb_sram_fifo_mc_1port;
   localparam int NCH = 4, W = 16, DEPTH = 64, NW = 6;
   logic            clk = 1'b0, rst = 1'b1;
   logic [NCH-1:0]  flush = '0, rd_en = '0;
   logic            wr_en = 1'b0;
   logic [1:0]      wr_ch = '0;
   logic [W-1:0]    wr_data = '0;
   logic [NCH-1:0]  full, rd_valid;
   logic [NCH*W-1:0]  rd_data;
   logic [NCH*NW-1:0] numel;
   logic            sram_ce, sram_we;
   logic [5:0]      sram_addr;
   logic [W-1:0]    sram_wdata, sram_rdata;
   logic [W-1:0]    mem [DEPTH];
   int checks = 0, errors = 0;

   sram_fifo_mc_1port #(.NCH(NCH), .WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .full(full), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .numel(numel),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (sram_ce) begin
         if (sram_we) mem[sram_addr] <= sram_wdata;
         else sram_rdata <= mem[sram_addr];
      end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] dat(input int ch);
      return rd_data[ch*W +: W];
   endfunction

   function automatic logic [NW-1:0] num(input int ch);
      return numel[ch*NW +: NW];
   endfunction

   task automatic reset_dut();
      rst = 1'b1; wr_en = 1'b0; rd_en = '0; flush = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wr(input int ch, input logic [W-1:0] d);
      wr_en = 1'b1; wr_ch = 2'(ch); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pop_ch(input int ch, input logic [W-1:0] exp, input string tag);
      int n = 0;
      while (!rd_valid[ch] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, rd_valid[ch], 1'b1);
      check(tag, dat(ch), exp);
      rd_en[ch] = 1'b1;
      @(negedge clk);
      rd_en[ch] = 1'b0;
   endtask

   task automatic scenario1(input string p);
      check({p, "_rst_valid"}, rd_valid, '0);
      check({p, "_rst_full"}, full, '0);
      check({p, "_rst_numel"}, numel, '0);
      check({p, "_rst_data"}, rd_data, '0);
      wr_en = 1'b1; wr_ch = 2'd2; wr_data = 16'hA5A5;
      #1 check({p, "_byp_ce"}, sram_ce, 1'b0);
      @(negedge clk);
      wr_en = 1'b0;
      check({p, "_valid"}, rd_valid, 4'b0100);
      check({p, "_data"}, dat(2), 16'hA5A5);
      check({p, "_numel"}, num(2), 6'd1);
   endtask

   initial begin
      int got [NCH];
      int glog [$];
      int total;
      // 1: bypass write
      reset_dut();
      scenario1("s1");
      // 2: fill ch1 to capacity, overflow dropped, drain in order
      reset_dut();
      for (int i = 0; i < 18; i++) begin
         wr_en = 1'b1; wr_ch = 2'd1; wr_data = 16'(i);
         #1 if (i == 17) check("s2_drop_ce", sram_ce, 1'b0);
         @(negedge clk);
         wr_en = 1'b0;
         if (i == 15) check("s2_not_full", full[1], 1'b0);
         if (i == 16) check("s2_full", full, 4'b0010);
      end
      check("s2_numel", num(1), 6'd17);
      for (int v = 0; v < 17; v++) pop_ch(1, 16'(v), $sformatf("s2_pop%0d", v));
      check("s2_empty", num(1), 6'd0);
      for (int v = 0; v < 3; v++) wr(1, 16'(100 + v));
      for (int v = 0; v < 3; v++) pop_ch(1, 16'(100 + v), $sformatf("s2_wrap%0d", v));
      // 3: round-robin refill with every channel popped each cycle
      reset_dut();
      for (int ch = 0; ch < NCH; ch++)
         for (int k = 0; k < 3; k++) wr(ch, 16'(ch * 16 + k));
      got = '{default: 0};
      total = 0;
      rd_en = '1;
      for (int cyc = 0; cyc < 40 && total < 12; cyc++) begin
         #1;
         if (sram_ce && !sram_we) glog.push_back(int'(sram_addr[5:4]));
         for (int ch = 0; ch < NCH; ch++)
            if (rd_valid[ch]) begin
               check($sformatf("s3_ch%0d_w%0d", ch, got[ch]), dat(ch), 16'(ch * 16 + got[ch]));
               got[ch]++;
               total++;
            end
         @(negedge clk);
      end
      rd_en = '0;
      for (int ch = 0; ch < NCH; ch++) check($sformatf("s3_count%0d", ch), got[ch], 3);
      check("s3_ngrant", glog.size(), 8);
      for (int i = 0; i < glog.size() && i < 8; i++) check($sformatf("s3_grant%0d", i), glog[i], i % 4);
      // 4: writes to ch0 starve the ch3 refill until the port goes idle
      reset_dut();
      wr(3, 16'h300); wr(3, 16'h301); wr(3, 16'h302); wr(0, 16'h000);
      wr_en = 1'b1; wr_ch = 2'd0;
      for (int i = 0; i < 5; i++) begin
         wr_data = 16'(1 + i);
         rd_en[3] = (i == 0);
         #1 check($sformatf("s4_we%0d", i), {sram_ce, sram_we}, 2'b11);
         @(negedge clk);
         check($sformatf("s4_hold%0d", i), rd_valid[3], 1'b0);
      end
      wr_en = 1'b0; rd_en = '0;
      #1 check("s4_rd", {sram_ce, sram_we}, 2'b10);
      check("s4_rd_addr", sram_addr, 6'd48);
      @(negedge clk);
      check("s4_fetch", rd_valid[3], 1'b0);
      check("s4_fetch_numel", num(3), 6'd2);
      @(negedge clk);
      check("s4_refilled", rd_valid[3], 1'b1);
      pop_ch(3, 16'h301, "s4_ch3_a");
      pop_ch(3, 16'h302, "s4_ch3_b");
      for (int v = 0; v < 6; v++) pop_ch(0, 16'(v), $sformatf("s4_ch0_%0d", v));
      // 5: flush while ch1 is fetching
      reset_dut();
      wr(0, 16'h1); wr(2, 16'h20); wr(2, 16'h21); wr(1, 16'h10); wr(1, 16'h11);
      rd_en[1] = 1'b1;
      #1 check("s5_rd", {sram_ce, sram_we, sram_addr}, {2'b10, 6'd16});
      @(negedge clk);
      rd_en = '0;
      check("s5_fetch_valid", rd_valid[1], 1'b0);
      check("s5_fetch_numel", num(1), 6'd1);
      flush = 4'b0010; wr_en = 1'b1; wr_ch = 2'd1; wr_data = 16'h12;
      #1 check("s5_wr_drop_ce", sram_ce, 1'b0);
      @(negedge clk);
      flush = '0; wr_en = 1'b0;
      check("s5_valid", rd_valid, 4'b0101);
      check("s5_numel1", num(1), 6'd0);
      check("s5_numel0", num(0), 6'd1);
      check("s5_numel2", num(2), 6'd2);
      check("s5_data2", dat(2), 16'h20);
      @(negedge clk);
      check("s5_still_empty", rd_valid[1], 1'b0);
      // 6: asynchronous reset in the middle of a write burst
      reset_dut();
      wr(0, 16'h50); wr(0, 16'h51);
      check("s6_pre_numel", num(0), 6'd2);
      wr_en = 1'b1; wr_ch = 2'd0; wr_data = 16'h52;
      #2 rst = 1'b1;
      #1;
      check("s6_valid", rd_valid, '0);
      check("s6_numel", numel, '0);
      check("s6_full", full, '0);
      check("s6_data", rd_data, '0);
      check("s6_sram", {sram_ce, sram_we}, 2'b00);
      @(negedge clk);
      rst = 1'b0; wr_en = 1'b0;
      scenario1("s6");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
endmodule
